lvds_panel_seq: RTL and testbench
=================================

# lvds_panel_seq

Panel sequencer and raster controller for the LVDS video path: waits for the DCM lock, runs the panel power-up and power-down order, and generates the raster counters, sync and data-enable strobes, and image-window RAM address that feed the LVDS encoder and pixel generator. It sits between the clock generation (DCM, pixel clock) and the `video_lvds` encoder. It replaces free-running raster counters with a controlled, restartable sequence.

## Interface
- SCREEN_X, 1366, active pixels per line
- SCREEN_Y, 768, active lines per frame
- HBLANK, 50, blanking pixels per line (H_TOTAL = 1416)
- VBLANK, 12, blanking lines per frame (V_TOTAL = 780)
- H_FP, 8, pixels from end of active line to hsync start
- HSYNC_W, 16, hsync width in pixels
- V_FP, 2, lines from end of active frame to vsync start
- VSYNC_W, 4, vsync width in lines
- WIN_W, 90 / WIN_H, 90, image-window size at top-left (WIN_W*WIN_H ≤ 8192)
- PWR_DLY, 1024, cycles between power-sequence steps (≥ 1)
- clk  in  1  pixel clock (the DCM CLKFX output)
- rst  in  1  synchronous, active-high reset
- locked  in  1  DCM lock; asynchronous to nothing, already in clk domain
- panel_en  out  1  panel logic supply enable
- lvds_en  out  1  encoder/LVDS output enable
- bl_en  out  1  backlight enable
- hsync, vsync  out  1  active-low syncs
- de  out  1  data enable
- x, y  out  11  current raster position
- frame_start  out  1  one-cycle pulse at x=0,y=0
- win_valid  out  1  x<WIN_W and y<WIN_H
- win_addr  out  13  image-window RAM address
- state  out  3  FSM state, for debug/LED

## Operation
- FSM states: OFF(0), WAIT_LOCK(1), PANEL_UP(2), VIDEO_UP(3), RUN(4), BL_DOWN(5), VIDEO_DOWN(6).
- OFF → WAIT_LOCK unconditionally next cycle after reset release.
- WAIT_LOCK: all enables 0; when locked=1 → PANEL_UP, panel_en=1, delay counter cleared.
- PANEL_UP: after PWR_DLY cycles → VIDEO_UP, lvds_en=1, raster starts at x=0,y=0.
- VIDEO_UP: after PWR_DLY cycles → RUN, bl_en=1.
- RUN: stays while locked=1.
- locked=0 in PANEL_UP/VIDEO_UP/RUN → BL_DOWN: bl_en=0 same cycle as entry.
- BL_DOWN: after PWR_DLY → VIDEO_DOWN, lvds_en=0, raster frozen and cleared to 0.
- VIDEO_DOWN: after PWR_DLY → WAIT_LOCK, panel_en=0.
- locked returning during BL_DOWN/VIDEO_DOWN is ignored; sequence completes.
- Raster runs only while lvds_en=1: x counts 0..H_TOTAL-1, wraps to 0 and increments y; y wraps 0 after V_TOTAL-1.
- de = x<SCREEN_X && y<SCREEN_Y.
- hsync=0 for SCREEN_X+H_FP ≤ x < SCREEN_X+H_FP+HSYNC_W, every line.
- vsync=0 for whole lines SCREEN_Y+V_FP ≤ y < SCREEN_Y+V_FP+VSYNC_W.
- win_addr: 0 at frame start; increments after each win_valid cycle; equals y*WIN_W+x while win_valid; holds otherwise.
- While lvds_en=0: hsync=vsync=1, de=0, frame_start=0, win_valid=0.

## Timing
- All outputs registered; de, syncs, frame_start, win_valid, win_addr describe the same x,y presented that cycle.
- Reset values: state=OFF, all enables 0, x=y=0, hsync=vsync=1, de=0, frame_start=0, win_valid=0, win_addr=0.
- Reset mid-operation: all outputs return to reset values next edge, no power-down sequence.
- First active pixel (x=0,y=0,de=1,frame_start=1) in the cycle lvds_en first reads 1.
- bl_en rises exactly PWR_DLY cycles after lvds_en; lvds_en exactly PWR_DLY after panel_en.
- Delay counter width ≥ clog2(PWR_DLY+1); no overflow.

## Structure
- Shared package: state encodings, H_TOTAL/V_TOTAL derivation, default panel geometry constants.
- One sub-module natural: `raster_counter` (x/y, syncs, de, window address) enabled by lvds_en; FSM in the top.

## Test plan
- rst, locked=1, PWR_DLY=4 → panel_en at cycle 2, lvds_en at 6, bl_en at 10; state 1,2,3,4.
- Run one frame → de high 1366 cycles per line, 768 lines; frame_start every 1416*780 cycles.
- Line check → hsync low for x=1374..1389 only; vsync low for y=770..773 only.
- Window → win_addr 0..89 on line 0, 90..179 on line 1, 8099 at x=89,y=89, back to 0 next frame.
- Drop locked in RUN → bl_en 0 next edge, lvds_en 0 after 4 cycles (x,y=0, de=0), panel_en 0 after 4 more, state=WAIT_LOCK.
- Assert rst mid-frame → all outputs at reset values next edge; locked held low keeps WAIT_LOCK.

Source files
------------

// File: rtl/lvds_panel_seq_pkg.sv
// Shared definitions for the LVDS panel sequencer: FSM encodings, raster widths,
// default panel geometry and total-count derivation.
package lvds_panel_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_PANEL_UP   = 3'd2,
        ST_VIDEO_UP   = 3'd3,
        ST_RUN        = 3'd4,
        ST_BL_DOWN    = 3'd5,
        ST_VIDEO_DOWN = 3'd6
    } state_e;

    localparam int POS_W  = 11;
    localparam int ADDR_W = 13;

    localparam int DEF_SCREEN_X = 1366;
    localparam int DEF_SCREEN_Y = 768;
    localparam int DEF_HBLANK   = 50;
    localparam int DEF_VBLANK   = 12;
    localparam int DEF_H_FP     = 8;
    localparam int DEF_HSYNC_W  = 16;
    localparam int DEF_V_FP     = 2;
    localparam int DEF_VSYNC_W  = 4;
    localparam int DEF_WIN_W    = 90;
    localparam int DEF_WIN_H    = 90;
    localparam int DEF_PWR_DLY  = 1024;

    // Total pixels per line or lines per frame: active region plus blanking.
    function automatic int raster_total(input int active, input int blank);
        return active + blank;
    endfunction

endpackage

// File: rtl/lvds_panel_seq_raster.sv
// Raster counter: x/y position, syncs, data enable, frame pulse and image-window
// address. All outputs are registered and describe the position presented that cycle.
module lvds_panel_seq_raster
    import lvds_panel_seq_pkg::*;
#(
    parameter int SCREEN_X = DEF_SCREEN_X,
    parameter int SCREEN_Y = DEF_SCREEN_Y,
    parameter int HBLANK   = DEF_HBLANK,
    parameter int VBLANK   = DEF_VBLANK,
    parameter int H_FP     = DEF_H_FP,
    parameter int HSYNC_W  = DEF_HSYNC_W,
    parameter int V_FP     = DEF_V_FP,
    parameter int VSYNC_W  = DEF_VSYNC_W,
    parameter int WIN_W    = DEF_WIN_W,
    parameter int WIN_H    = DEF_WIN_H
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    output logic [POS_W-1:0]  x_o,
    output logic [POS_W-1:0]  y_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              de_o,
    output logic              frame_start_o,
    output logic              win_valid_o,
    output logic [ADDR_W-1:0] win_addr_o
);

    localparam logic [POS_W-1:0] H_LAST   = POS_W'(raster_total(SCREEN_X, HBLANK) - 1);
    localparam logic [POS_W-1:0] V_LAST   = POS_W'(raster_total(SCREEN_Y, VBLANK) - 1);
    localparam logic [POS_W-1:0] SX       = POS_W'(SCREEN_X);
    localparam logic [POS_W-1:0] SY       = POS_W'(SCREEN_Y);
    localparam logic [POS_W-1:0] HS_START = POS_W'(SCREEN_X + H_FP);
    localparam logic [POS_W-1:0] HS_END   = POS_W'(SCREEN_X + H_FP + HSYNC_W);
    localparam logic [POS_W-1:0] VS_START = POS_W'(SCREEN_Y + V_FP);
    localparam logic [POS_W-1:0] VS_END   = POS_W'(SCREEN_Y + V_FP + VSYNC_W);
    localparam logic [POS_W-1:0] WW       = POS_W'(WIN_W);
    localparam logic [POS_W-1:0] WH       = POS_W'(WIN_H);

    logic              active_q;
    logic [POS_W-1:0]  x_q, x_d, y_q, y_d;
    logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic              fs_q, fs_d, wv_q, wv_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // The first enabled cycle presents (0,0); the counters advance only once
    // the raster was already running on the previous cycle.
    always_comb begin
        x_d = '0;
        y_d = '0;
        if (run_i && active_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + POS_W'(1);
            end else begin
                x_d = x_q + POS_W'(1);
                y_d = y_q;
            end
        end

        de_d = run_i && (x_d < SX) && (y_d < SY);
        hs_d = !(run_i && (x_d >= HS_START) && (x_d < HS_END));
        vs_d = !(run_i && (y_d >= VS_START) && (y_d < VS_END));
        fs_d = run_i && (x_d == '0) && (y_d == '0);
        wv_d = run_i && (x_d < WW) && (y_d < WH);

        // Window address steps after every window pixel and holds elsewhere,
        // so it equals y*WIN_W+x on each window pixel.
        if (!run_i || fs_d) begin
            addr_d = '0;
        end else if (wv_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end else begin
            addr_d = addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            de_q     <= 1'b0;
            fs_q     <= 1'b0;
            wv_q     <= 1'b0;
            addr_q   <= '0;
        end else begin
            active_q <= run_i;
            x_q      <= x_d;
            y_q      <= y_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            de_q     <= de_d;
            fs_q     <= fs_d;
            wv_q     <= wv_d;
            addr_q   <= addr_d;
        end
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign hsync_o       = hs_q;
    assign vsync_o       = vs_q;
    assign de_o          = de_q;
    assign frame_start_o = fs_q;
    assign win_valid_o   = wv_q;
    assign win_addr_o    = addr_q;

endmodule

// File: rtl/lvds_panel_seq.sv
// Panel power sequencer and raster controller: waits for DCM lock, steps the panel,
// LVDS and backlight enables in order, and runs the raster while LVDS is enabled.
module lvds_panel_seq
    import lvds_panel_seq_pkg::*;
#(
    parameter int SCREEN_X = DEF_SCREEN_X,
    parameter int SCREEN_Y = DEF_SCREEN_Y,
    parameter int HBLANK   = DEF_HBLANK,
    parameter int VBLANK   = DEF_VBLANK,
    parameter int H_FP     = DEF_H_FP,
    parameter int HSYNC_W  = DEF_HSYNC_W,
    parameter int V_FP     = DEF_V_FP,
    parameter int VSYNC_W  = DEF_VSYNC_W,
    parameter int WIN_W    = DEF_WIN_W,
    parameter int WIN_H    = DEF_WIN_H,
    parameter int PWR_DLY  = DEF_PWR_DLY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              locked,
    output logic              panel_en,
    output logic              lvds_en,
    output logic              bl_en,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [POS_W-1:0]  x,
    output logic [POS_W-1:0]  y,
    output logic              frame_start,
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_addr,
    output logic [2:0]        state
);

    localparam int               CNT_W    = $clog2(PWR_DLY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWR_DLY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             panel_q, panel_d, lvds_q, lvds_d, bl_q, bl_d;
    logic             dly_done;

    assign dly_done = (cnt_q == CNT_LAST);

    // Delay counter is cleared on every state change; each timed state leaves
    // after exactly PWR_DLY cycles. Lock loss only matters on the way up or in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        panel_d = panel_q;
        lvds_d  = lvds_q;
        bl_d    = bl_q;
        case (state_q)
            ST_OFF: begin
                state_d = ST_WAIT_LOCK;
                panel_d = 1'b0;
                lvds_d  = 1'b0;
                bl_d    = 1'b0;
            end
            ST_WAIT_LOCK: begin
                panel_d = 1'b0;
                lvds_d  = 1'b0;
                bl_d    = 1'b0;
                if (locked) begin
                    state_d = ST_PANEL_UP;
                    panel_d = 1'b1;
                end
            end
            ST_PANEL_UP: begin
                if (!locked) begin
                    state_d = ST_BL_DOWN;
                    bl_d    = 1'b0;
                end else if (dly_done) begin
                    state_d = ST_VIDEO_UP;
                    lvds_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_VIDEO_UP: begin
                if (!locked) begin
                    state_d = ST_BL_DOWN;
                    bl_d    = 1'b0;
                end else if (dly_done) begin
                    state_d = ST_RUN;
                    bl_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!locked) begin
                    state_d = ST_BL_DOWN;
                    bl_d    = 1'b0;
                end
            end
            ST_BL_DOWN: begin
                if (dly_done) begin
                    state_d = ST_VIDEO_DOWN;
                    lvds_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_VIDEO_DOWN: begin
                if (dly_done) begin
                    state_d = ST_WAIT_LOCK;
                    panel_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                panel_d = 1'b0;
                lvds_d  = 1'b0;
                bl_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            panel_q <= 1'b0;
            lvds_q  <= 1'b0;
            bl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            panel_q <= panel_d;
            lvds_q  <= lvds_d;
            bl_q    <= bl_d;
        end
    end

    // Raster follows the next-cycle LVDS enable so pixel (0,0) appears together
    // with the first cycle lvds_en reads 1.
    lvds_panel_seq_raster #(
        .SCREEN_X (SCREEN_X),
        .SCREEN_Y (SCREEN_Y),
        .HBLANK   (HBLANK),
        .VBLANK   (VBLANK),
        .H_FP     (H_FP),
        .HSYNC_W  (HSYNC_W),
        .V_FP     (V_FP),
        .VSYNC_W  (VSYNC_W),
        .WIN_W    (WIN_W),
        .WIN_H    (WIN_H)
    ) u_raster (
        .clk           (clk),
        .rst           (rst),
        .run_i         (lvds_d),
        .x_o           (x),
        .y_o           (y),
        .hsync_o       (hsync),
        .vsync_o       (vsync),
        .de_o          (de),
        .frame_start_o (frame_start),
        .win_valid_o   (win_valid),
        .win_addr_o    (win_addr)
    );

    assign panel_en = panel_q;
    assign lvds_en  = lvds_q;
    assign bl_en    = bl_q;
    assign state    = state_q;

endmodule

// File: tb/tb_lvds_panel_seq.sv
// Directed bench for lvds_panel_seq on a reduced geometry: 30x18 total raster,
// 20x12 active, hsync x=23..26, vsync y=14..15, 5x4 window, PWR_DLY=4.
module tb_lvds_panel_seq;

  logic        clk;
  logic        rst;
  logic        locked;
  logic        panel_en, lvds_en, bl_en;
  logic        hsync, vsync, de;
  logic [10:0] x, y;
  logic        frame_start, win_valid;
  logic [12:0] win_addr;
  logic [2:0]  state;

  int total;
  int bad;

  lvds_panel_seq #(
    .SCREEN_X (20),
    .SCREEN_Y (12),
    .HBLANK   (10),
    .VBLANK   (6),
    .H_FP     (3),
    .HSYNC_W  (4),
    .V_FP     (2),
    .VSYNC_W  (2),
    .WIN_W    (5),
    .WIN_H    (4),
    .PWR_DLY  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .locked      (locked),
    .panel_en    (panel_en),
    .lvds_en     (lvds_en),
    .bl_en       (bl_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .win_valid   (win_valid),
    .win_addr    (win_addr),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {state, panel, lvds, bl, x, y, hsync, vsync, de, frame_start, win_valid, win_addr}
  localparam logic [45:0] RESET_VEC = {3'd0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0,
                                       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13'd0};

  task automatic test_reset();
    logic [45:0] act;
    rst = 1'b1;
    locked = 1'b0;
    repeat (3) tick();
    act = {state, panel_en, lvds_en, bl_en, x, y, hsync, vsync, de, frame_start, win_valid, win_addr};
    total++;
    if (act !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_values got=%h exp=%h", act, RESET_VEC);
    end
  endtask

  task automatic test_power_up();
    logic [5:0]  act, exp;
    logic [2:0]  e_st;
    logic [39:0] ract, rexp;
    locked = 1'b1;
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      e_st = (c == 1) ? 3'd1 : (c < 6) ? 3'd2 : (c < 10) ? 3'd3 : 3'd4;
      exp = {e_st, c >= 2, c >= 6, c >= 10};
      act = {state, panel_en, lvds_en, bl_en};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL power_up_c%0d got=%h exp=%h", c, act, exp);
      end
      if (c == 6) begin
        ract = {x, y, de, hsync, vsync, frame_start, win_valid, win_addr};
        rexp = {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 13'd0};
        total++;
        if (ract !== rexp) begin
          bad++;
          $display("FAIL first_pixel got=%h exp=%h", ract, rexp);
        end
      end
    end
  endtask

  // Starts in RUN at (4,0) and walks one full 540-cycle frame back to (4,0).
  task automatic test_frame();
    logic [10:0] ex, ey;
    logic        e_de, e_hs, e_vs, e_fs, e_wv;
    logic [12:0] e_addr;
    logic [39:0] act, exp;
    int de_cnt, fs_cnt, hs_cnt, vs_cnt;
    int hs_min, hs_max, vs_min, vs_max;
    ex = 11'd4;
    ey = 11'd0;
    de_cnt = 0; fs_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    hs_min = 2047; hs_max = 0; vs_min = 2047; vs_max = 0;
    for (int n = 0; n < 540; n++) begin
      tick();
      if (ex == 11'd29) begin
        ex = 11'd0;
        ey = (ey == 11'd17) ? 11'd0 : ey + 11'd1;
      end else begin
        ex = ex + 11'd1;
      end
      e_de = (ex < 20) && (ey < 12);
      e_hs = !((ex >= 23) && (ex < 27));
      e_vs = !((ey >= 14) && (ey < 16));
      e_fs = (ex == 0) && (ey == 0);
      e_wv = (ex < 5) && (ey < 4);
      if (ey < 4) e_addr = (ex < 5) ? 13'(ey * 5 + ex) : 13'(ey * 5 + 5);
      else        e_addr = 13'd20;
      exp = {ex, ey, e_de, e_hs, e_vs, e_fs, e_wv, e_addr};
      act = {x, y, de, hsync, vsync, frame_start, win_valid, win_addr};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL raster_x%0d_y%0d got=%h exp=%h", ex, ey, act, exp);
      end
      if (de === 1'b1) de_cnt++;
      if (frame_start === 1'b1) fs_cnt++;
      if (hsync === 1'b0) begin
        hs_cnt++;
        if (int'(x) < hs_min) hs_min = int'(x);
        if (int'(x) > hs_max) hs_max = int'(x);
      end
      if (vsync === 1'b0) begin
        vs_cnt++;
        if (int'(y) < vs_min) vs_min = int'(y);
        if (int'(y) > vs_max) vs_max = int'(y);
      end
    end
    total++;
    if (de_cnt != 240) begin bad++; $display("FAIL de_count got=%0d exp=240", de_cnt); end
    total++;
    if (fs_cnt != 1) begin bad++; $display("FAIL frame_start_count got=%0d exp=1", fs_cnt); end
    total++;
    if (hs_cnt != 72 || hs_min != 23 || hs_max != 26) begin
      bad++;
      $display("FAIL hsync_span got=%0d/%0d..%0d exp=72/23..26", hs_cnt, hs_min, hs_max);
    end
    total++;
    if (vs_cnt != 60 || vs_min != 14 || vs_max != 15) begin
      bad++;
      $display("FAIL vsync_span got=%0d/%0d..%0d exp=60/14..15", vs_cnt, vs_min, vs_max);
    end
    total++;
    if ({state, bl_en} !== {3'd4, 1'b1}) begin
      bad++;
      $display("FAIL still_run got=%h exp=%h", {state, bl_en}, {3'd4, 1'b1});
    end
  endtask

  // Lock drops in RUN; a brief lock return during BL_DOWN must be ignored.
  task automatic test_power_down();
    logic [5:0]  act, exp;
    logic [2:0]  e_st;
    logic [39:0] ract, rexp;
    locked = 1'b0;
    for (int d = 1; d <= 12; d++) begin
      tick();
      if (d == 2) locked = 1'b1;
      if (d == 6) locked = 1'b0;
      e_st = (d < 5) ? 3'd5 : (d < 9) ? 3'd6 : 3'd1;
      exp = {e_st, d < 9, d < 5, 1'b0};
      act = {state, panel_en, lvds_en, bl_en};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL power_down_d%0d got=%h exp=%h", d, act, exp);
      end
      if (d == 5) begin
        ract = {x, y, de, hsync, vsync, frame_start, win_valid, win_addr};
        rexp = {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 13'd0};
        total++;
        if (ract !== rexp) begin
          bad++;
          $display("FAIL raster_idle got=%h exp=%h", ract, rexp);
        end
      end
    end
  endtask

  // Lock lost while still in PANEL_UP: full down sequence, raster never starts.
  task automatic test_drop_early();
    logic [7:0] act, exp;
    logic [2:0] e_st;
    locked = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e == 2) locked = 1'b0;
      e_st = (e < 3) ? 3'd2 : (e < 7) ? 3'd5 : (e < 11) ? 3'd6 : 3'd1;
      exp = {e_st, e < 11, 1'b0, 1'b0, 1'b0, 1'b1};
      act = {state, panel_en, lvds_en, bl_en, de, hsync};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL drop_early_e%0d got=%h exp=%h", e, act, exp);
      end
    end
  endtask

  // Reset mid-frame while running, then hold locked low in WAIT_LOCK.
  task automatic test_reset_mid();
    logic [45:0] act;
    logic [24:0] pact, pexp;
    locked = 1'b1;
    repeat (109) tick();
    pact = {state, x, y};
    pexp = {3'd4, 11'd14, 11'd3};
    total++;
    if (pact !== pexp) begin
      bad++;
      $display("FAIL mid_frame_pos got=%h exp=%h", pact, pexp);
    end
    rst = 1'b1;
    locked = 1'b0;
    tick();
    act = {state, panel_en, lvds_en, bl_en, x, y, hsync, vsync, de, frame_start, win_valid, win_addr};
    total++;
    if (act !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_mid got=%h exp=%h", act, RESET_VEC);
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if ({state, panel_en, lvds_en, bl_en, de} !== {3'd1, 4'b0000}) begin
        bad++;
        $display("FAIL wait_lock_k%0d got=%h exp=%h", k, {state, panel_en, lvds_en, bl_en, de}, {3'd1, 4'b0000});
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    locked = 1'b0;
    test_reset();
    test_power_up();
    test_frame();
    test_power_down();
    test_drop_early();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
